list_cmd_sequencer: RTL and testbench

//  Front-end that feeds the list block. Accepts list commands over a valid/ready stream,

---
 rtl/list_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_list_cmd_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_cmd_sequencer.sv
// Command front-end for the list block: buffers commands in a small FIFO, issues them
// one at a time, and returns each list result in order with a watchdog abort.
module list_cmd_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int LENGTH         = 8,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LENGTH_WIDTH  = $clog2(LENGTH),
  localparam int RESULT_WIDTH  = DATA_WIDTH + LENGTH_WIDTH,
  localparam int COUNT_WIDTH   = $clog2(CMD_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [LENGTH_WIDTH-1:0] cmd_index,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic [2:0]              list_op_sel,
  output logic                    list_op_en,
  output logic [LENGTH_WIDTH-1:0] list_index_in,
  output logic [DATA_WIDTH-1:0]   list_data_in,
  input  logic [RESULT_WIDTH-1:0] list_data_out,
  input  logic                    list_op_done,
  input  logic                    list_op_error,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_op,
  output logic [RESULT_WIDTH-1:0] rsp_data,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [COUNT_WIDTH-1:0]  fifo_count,
  output logic                    busy
);

  localparam int PTR_WIDTH   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int ENTRY_WIDTH = 3 + LENGTH_WIDTH + DATA_WIDTH;
  localparam int WDOG_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST =
    WDOG_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WDOG_WIDTH-1:0] WDOG_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(CMD_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  // Command FIFO
  logic [ENTRY_WIDTH-1:0]  fifo_mem [CMD_DEPTH];
  logic [PTR_WIDTH-1:0]    wr_ptr_reg;
  logic [PTR_WIDTH-1:0]    rd_ptr_reg;
  logic [COUNT_WIDTH-1:0]  count_reg;
  logic                    push;
  logic                    pop;
  logic [2:0]              head_op;
  logic [LENGTH_WIDTH-1:0] head_index;
  logic [DATA_WIDTH-1:0]   head_data;

  assign cmd_ready  = (count_reg != FULL_COUNT);
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = count_reg;
  assign {head_op, head_index, head_data} = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_index, cmd_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_WIDTH'(1);
        2'b01:   count_reg <= count_reg - COUNT_WIDTH'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Issue / response FSM; every list-facing and response output is a register
  state_t                  state_reg, state_next;
  logic [2:0]              op_sel_reg, op_sel_next;
  logic                    op_en_reg, op_en_next;
  logic [LENGTH_WIDTH-1:0] index_reg, index_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [2:0]              rsp_op_reg, rsp_op_next;
  logic [RESULT_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                    rsp_error_reg, rsp_error_next;
  logic                    rsp_timeout_reg, rsp_timeout_next;
  logic [WDOG_WIDTH-1:0]   wdog_reg, wdog_next;
  logic                    wdog_expired;

  assign wdog_expired = (TIMEOUT_CYCLES != 0) && (wdog_reg == WDOG_LAST);

  always_comb begin
    state_next       = state_reg;
    op_sel_next      = op_sel_reg;
    op_en_next       = op_en_reg;
    index_next       = index_reg;
    data_next        = data_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_op_next      = rsp_op_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_error_next   = rsp_error_reg;
    rsp_timeout_next = rsp_timeout_reg;
    wdog_next        = wdog_reg;
    pop              = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0) begin
          pop         = 1'b1;
          op_sel_next = head_op;
          index_next  = head_index;
          data_next   = head_data;
          op_en_next  = 1'b1;
          wdog_next   = '0;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completion in the same cycle as the watchdog expiring still counts as success
        if (list_op_done) begin
          rsp_data_next    = list_data_out;
          rsp_error_next   = list_op_error;
          rsp_op_next      = op_sel_reg;
          rsp_timeout_next = 1'b0;
          op_en_next       = 1'b0;
          rsp_valid_next   = 1'b1;
          state_next       = ST_RESP;
        end else if (wdog_expired) begin
          rsp_data_next    = '0;
          rsp_error_next   = 1'b1;
          rsp_op_next      = op_sel_reg;
          rsp_timeout_next = 1'b1;
          op_en_next       = 1'b0;
          rsp_valid_next   = 1'b1;
          state_next       = ST_RESP;
        end else if (wdog_reg != WDOG_MAX) begin
          wdog_next = wdog_reg + WDOG_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      op_sel_reg      <= '0;
      op_en_reg       <= 1'b0;
      index_reg       <= '0;
      data_reg        <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_op_reg      <= '0;
      rsp_data_reg    <= '0;
      rsp_error_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      wdog_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      op_sel_reg      <= op_sel_next;
      op_en_reg       <= op_en_next;
      index_reg       <= index_next;
      data_reg        <= data_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_op_reg      <= rsp_op_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_error_reg   <= rsp_error_next;
      rsp_timeout_reg <= rsp_timeout_next;
      wdog_reg        <= wdog_next;
    end
  end

  assign list_op_sel   = op_sel_reg;
  assign list_op_en    = op_en_reg;
  assign list_index_in = index_reg;
  assign list_data_in  = data_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_op        = rsp_op_reg;
  assign rsp_data      = rsp_data_reg;
  assign rsp_error     = rsp_error_reg;
  assign rsp_timeout   = rsp_timeout_reg;
  assign busy          = (state_reg != ST_IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_list_cmd_sequencer.sv
// Bench for list_cmd_sequencer: a behavioural list model answers issued ops with random
// latency while a separate reference list predicts every response in command order.
module tb_list_cmd_sequencer;
  localparam int DW = 8, LEN = 8, LW = 3, OW = 11, DEPTH = 4, TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [LW-1:0] cmd_index;
  logic [DW-1:0] cmd_data;
  logic [2:0]    list_op_sel;
  logic          list_op_en;
  logic [LW-1:0] list_index_in;
  logic [DW-1:0] list_data_in;
  logic [OW-1:0] list_data_out;
  logic          list_op_done, list_op_error;
  logic          rsp_valid, rsp_ready;
  logic [2:0]    rsp_op;
  logic [OW-1:0] rsp_data;
  logic          rsp_error, rsp_timeout;
  logic [2:0]    fifo_count;
  logic          busy;

  list_cmd_sequencer #(.DATA_WIDTH(DW), .LENGTH(LEN), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_data(cmd_data),
    .list_op_sel(list_op_sel), .list_op_en(list_op_en), .list_index_in(list_index_in),
    .list_data_in(list_data_in), .list_data_out(list_data_out),
    .list_op_done(list_op_done), .list_op_error(list_op_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .fifo_count(fifo_count), .busy(busy)
  );

  typedef struct {
    logic [2:0]    op;
    logic [OW-1:0] data;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t exp_q[$];
  bit   hang_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp = 0;
  logic [OW-1:0] last_data;
  logic [2:0]    last_op;
  logic          last_err, last_tmo;
  bit   ready_mode = 1'b0;   // 0: rsp_ready = ready_force, 1: random
  bit   ready_force = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Two independent list images: [0] = reference at command accept, [1] = list block model
  logic [DW-1:0] lst [2][LEN];
  int            lsz [2];

  function automatic void list_exec(input int w, input logic [2:0] op, input logic [LW-1:0] idx,
                                    input logic [DW-1:0] din,
                                    output logic [OW-1:0] dout, output logic err);
    int cnt;
    logic [DW-1:0] t;
    dout = '0;
    err  = 1'b0;
    case (op)
      3'd0: if (int'(idx) >= lsz[w]) err = 1'b1; else dout = OW'(lst[w][idx]);
      3'd1: begin
        if (lsz[w] == LEN || int'(idx) > lsz[w]) err = 1'b1;
        else begin
          for (int i = lsz[w]; i > int'(idx); i--) lst[w][i] = lst[w][i-1];
          lst[w][idx] = din;
          lsz[w]++;
        end
      end
      3'd2: begin
        cnt = 0;
        for (int i = 0; i < lsz[w]; i++) if (lst[w][i] == din) cnt++;
        dout = OW'(cnt);
        err  = (cnt == 0);
      end
      3'd3: begin
        err = 1'b1;
        for (int i = lsz[w] - 1; i >= 0; i--)
          if (lst[w][i] == din) begin dout = OW'(i); err = 1'b0; end
      end
      3'd4: begin
        for (int i = 0; i < lsz[w]; i++) dout = dout + OW'(lst[w][i]);
        err = (lsz[w] == 0);
      end
      3'd5, 3'd6: begin
        for (int i = 0; i < lsz[w]; i++)
          for (int j = 0; j < lsz[w] - 1 - i; j++)
            if ((op == 3'd5) ? (lst[w][j] > lst[w][j+1]) : (lst[w][j] < lst[w][j+1])) begin
              t = lst[w][j]; lst[w][j] = lst[w][j+1]; lst[w][j+1] = t;
            end
      end
      default: begin
        if (int'(idx) >= lsz[w]) err = 1'b1;
        else begin
          dout = OW'(lst[w][idx]);
          for (int i = int'(idx); i < lsz[w] - 1; i++) lst[w][i] = lst[w][i+1];
          lsz[w]--;
        end
      end
    endcase
  endfunction

  // List block model: random 0..5 cycle latency, or never answers when the op is tagged hang
  initial begin
    bit pending, served, hang;
    int wait_left;
    logic [OW-1:0] d;
    logic e;
    pending = 0; served = 0; hang = 0; wait_left = 0;
    list_op_done = 1'b0; list_data_out = '0; list_op_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      list_op_done = 1'b0;
      if (rst || !list_op_en) pending = 0;
      else if (!pending) begin
        pending = 1; served = 0;
        hang = (hang_q.size() > 0) ? hang_q.pop_front() : 1'b0;
        wait_left = $urandom_range(0, 5);
      end
      if (pending && !served && !hang) begin
        if (wait_left == 0) begin
          list_exec(1, list_op_sel, list_index_in, list_data_in, d, e);
          list_data_out = d; list_op_error = e; list_op_done = 1'b1; served = 1;
        end else wait_left--;
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rsp_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Response scoreboard: handshake seen at negedge completes at the following posedge
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check_eq("rsp_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("rsp_op", rsp_op, e.op);
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_error", rsp_error, e.err);
          check_eq("rsp_timeout", rsp_timeout, e.tmo);
          n_rsp++;
          last_data = rsp_data; last_op = rsp_op; last_err = rsp_error; last_tmo = rsp_timeout;
          $display("rsp %0d: op=%0d data=%0h err=%0b tmo=%0b", n_rsp, rsp_op, rsp_data, rsp_error, rsp_timeout);
        end
      end
    end
  end

  // op_en must stay low for at least two cycles between consecutive ops
  initial begin
    bit seen_op, prev_en;
    int low_run;
    seen_op = 0; prev_en = 0; low_run = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin seen_op = 0; prev_en = 0; low_run = 0; end
      else begin
        if (list_op_en && !prev_en) begin
          if (seen_op) check_eq("op_en_gap", 32'(low_run >= 2), 1);
          seen_op = 1; low_run = 0;
        end
        if (!list_op_en) low_run++;
        prev_en = list_op_en;
      end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [LW-1:0] idx,
                          input logic [DW-1:0] din, input bit hang);
    rsp_t e;
    int budget;
    bit ok;
    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx; cmd_data = din;
    budget = 0; ok = 0;
    while (!ok && budget <= 300) begin
      @(negedge clk);
      if (cmd_ready) ok = 1; else budget++;
    end
    if (!ok) check_eq("cmd_accept_timeout", cmd_ready, 1);
    else begin
      e.op = op;
      if (hang) begin e.data = '0; e.err = 1'b1; e.tmo = 1'b1; end
      else begin list_exec(0, op, idx, din, e.data, e.err); e.tmo = 1'b0; end
      exp_q.push_back(e);
      hang_q.push_back(hang);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin @(posedge clk); budget++; end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, cnt;
    for (int w = 0; w < 2; w++) begin
      lsz[w] = 0;
      for (int i = 0; i < LEN; i++) lst[w][i] = '0;
    end
    cmd_valid = 1'b0; cmd_op = '0; cmd_index = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_op_en", list_op_en, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;

    // Reset in the middle of a WAIT abandons the op without a response
    send_cmd(3'd0, 3'd0, 8'd0, 1'b1);
    cnt = 0;
    while (!list_op_en && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check_eq("t1_op_en_before_rst", list_op_en, 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("t1_op_en_async", list_op_en, 0);
    check_eq("t1_rsp_valid_async", rsp_valid, 0);
    check_eq("t1_fifo_count", fifo_count, 0);
    check_eq("t1_cmd_ready", cmd_ready, 1);
    exp_q.delete(); hang_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Insert(0,5), Insert(1,9), Read(1) back-to-back
    base = n_rsp;
    send_cmd(3'd1, 3'd0, 8'd5, 1'b0);
    send_cmd(3'd1, 3'd1, 8'd9, 1'b0);
    send_cmd(3'd0, 3'd1, 8'd0, 1'b0);
    drain();
    check_eq("t2_rsp_count", n_rsp - base, 3);
    check_eq("t2_read_data", last_data, 9);
    check_eq("t2_read_err", last_err, 0);

    // Out-of-range read on a two-element list
    send_cmd(3'd0, 3'd3, 8'd0, 1'b0);
    drain();
    check_eq("t4_err", last_err, 1);
    check_eq("t4_tmo", last_tmo, 0);
    check_eq("t4_op", last_op, 0);

    // Backpressure: FIFO fills behind a stuck response
    ready_force = 1'b0;
    @(posedge clk); #1;
    send_cmd(3'd1, 3'd0, 8'd1, 1'b0);
    send_cmd(3'd1, 3'd0, 8'd2, 1'b0);
    send_cmd(3'd1, 3'd0, 8'd3, 1'b0);
    send_cmd(3'd1, 3'd0, 8'd4, 1'b0);
    send_cmd(3'd0, 3'd0, 8'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("t3_fifo_count", fifo_count, 4);
    check_eq("t3_cmd_ready", cmd_ready, 0);
    check_eq("t3_rsp_valid", rsp_valid, 1);
    ready_mode = 1'b1;
    send_cmd(3'd0, 3'd2, 8'd0, 1'b0);
    drain();

    // Watchdog abort, then the next command runs normally
    ready_mode = 1'b0; ready_force = 1'b1;
    @(posedge clk); #1;
    send_cmd(3'd4, 3'd0, 8'd0, 1'b1);
    fork
      begin
        int c;
        c = 0;
        while (!list_op_en && c < 20) begin @(posedge clk); #1; c++; end
        c = 0;
        while (!rsp_valid && c < 100) begin @(posedge clk); #1; c++; end
        check_eq("t5_wait_cycles", c, 16);
        check_eq("t5_tmo", rsp_timeout, 1);
        check_eq("t5_err", rsp_error, 1);
        check_eq("t5_data", rsp_data, 0);
      end
      send_cmd(3'd0, 3'd0, 8'd0, 1'b0);
    join
    drain();
    check_eq("t5_next_tmo", last_tmo, 0);

    // Random traffic with random response backpressure
    ready_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    drain();
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
